// File: rtl/idct_da_odd_if.sv
// idct_da_odd_if: stream bundle for the odd-half inverse DCT (coefficients in, difference terms out)
//   in_data/in_valid/in_ready        : signed 18-bit Y[k] stream, k given by arrival order
//   out_data/out_idx/out_valid/
//   out_ready/out_last               : signed 21-bit d[n] stream with its index n, last at n==7
//   master: the side that feeds coefficients and accepts results; slave: the datapath
interface idct_da_odd_if;
    logic signed [17:0] in_data;
    logic               in_valid;
    logic               in_ready;
    logic signed [20:0] out_data;
    logic [2:0]         out_idx;
    logic               out_valid;
    logic               out_ready;
    logic               out_last;
    modport master(output in_data, in_valid, out_ready, input in_ready, out_data, out_idx, out_valid, out_last);
    modport slave(input in_data, in_valid, out_ready, output in_ready, out_data, out_idx, out_valid, out_last);
endinterface

// File: rtl/idct_da_odd.sv
// idct_da_odd: bit-serial distributed-arithmetic rebuild of d[n] = x[n]-x[15-n] from 8 odd DCT coefficients
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : idct_da_odd_if.slave (in_* coefficient stream, out_* result stream)
module idct_da_odd #(
    parameter int NC = 8,
    parameter int BW = 18,
    parameter int CW = 15,
    parameter int OW = 21
) (
    input logic         clk,
    input logic         rst,
    idct_da_odd_if.slave bus
);
    typedef enum logic [1:0] {LOAD, COMP, EMIT} state_t;

    state_t             state;
    logic signed [BW-1:0] y [NC];
    logic [2:0]         cnt;
    logic [2:0]         row;
    logic [4:0]         j;
    logic signed [37:0] acc;
    logic signed [37:0] acc_next;
    logic signed [37:0] term;
    logic signed [18:0] lut;
    logic signed [18:0] lut_all [NC];
    logic [NC-1:0]      addr;

    // round(2^14*cos(m*pi/32)) for odd m, folded onto the first quadrant
    function automatic logic signed [CW-1:0] coef(input int n, input int k);
        int m, r, v;
        bit neg;
        m = ((2*n+1)*(2*k+1)) % 64;
        r = m < 16 ? m : m < 32 ? 32-m : m < 48 ? m-32 : 64-m;
        neg = (m > 16) && (m < 48);
        v = r == 1 ? 16305 : r == 3 ? 15679 : r == 5 ? 14449 : r == 7 ? 12665 :
            r == 9 ? 10394 : r == 11 ? 7723 : r == 13 ? 4756 : 1606;
        return CW'(neg ? -v : v);
    endfunction

    // Bit j of every Y forms the DA address, Y0 in the MSB
    always_comb begin
        addr = '0;
        for (int k = 0; k < NC; k++) addr[NC-1-k] = y[k][j];
    end

    for (genvar i = 0; i < NC; i++) begin : g_lut
        logic signed [18:0] s;
        always_comb begin
            s = '0;
            for (int k = 0; k < NC; k++) if (addr[NC-1-k]) s = s + 19'(coef(i, k));
        end
        assign lut_all[i] = s;
    end

    // The top bit of a two's-complement Y carries weight -2^17, hence the subtract
    always_comb begin
        lut = lut_all[row];
        term = {{19{lut[18]}}, lut} <<< j;
        acc_next = (j == 5'(BW-1)) ? acc - term : acc + term;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LOAD;
            cnt <= '0;
            row <= '0;
            j <= '0;
            acc <= '0;
            bus.in_ready <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.out_last <= 1'b0;
            bus.out_data <= '0;
            bus.out_idx <= '0;
        end else begin
            case (state)
                LOAD: if (bus.in_valid && bus.in_ready) begin
                    y[cnt] <= bus.in_data;
                    cnt <= cnt + 3'd1;
                    if (cnt == 3'(NC-1)) begin
                        state <= COMP;
                        row <= '0;
                        j <= '0;
                        acc <= '0;
                        bus.in_ready <= 1'b0;
                    end
                end
                COMP: begin
                    acc <= acc_next;
                    j <= j + 5'd1;
                    if (j == 5'(BW-1)) begin
                        bus.out_data <= acc_next[OW+13:14];
                        bus.out_idx <= row;
                        bus.out_last <= (row == 3'(NC-1));
                        bus.out_valid <= 1'b1;
                        state <= EMIT;
                    end
                end
                EMIT: if (bus.out_ready) begin
                    bus.out_valid <= 1'b0;
                    bus.out_last <= 1'b0;
                    if (row == 3'(NC-1)) begin
                        state <= LOAD;
                        cnt <= '0;
                        bus.in_ready <= 1'b1;
                    end else begin
                        row <= row + 3'd1;
                        acc <= '0;
                        j <= '0;
                        state <= COMP;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_idct_da_odd.sv
// tb_idct_da_odd: scoreboard bench for idct_da_odd
module tb_idct_da_odd;
    typedef logic signed [17:0] blk_t [8];
    typedef struct {
        logic [20:0] data;
        logic [2:0]  idx;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    exp_t exp_q[$];
    int imp [8] = '{16305, 15679, 14449, 12665, 10394, 7723, 4756, 1606};

    idct_da_odd_if bus();
    idct_da_odd dut(.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output idx=%0d data=%0d with empty scoreboard", bus.out_idx, $signed(bus.out_data));
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                checks++;
                if (bus.out_data !== e.data || bus.out_idx !== e.idx || bus.out_last !== (e.idx == 3'd7)) begin
                    errors++;
                    $display("FAIL output got data=%0d idx=%0d last=%b expected data=%0d idx=%0d last=%b",
                             $signed(bus.out_data), bus.out_idx, bus.out_last, $signed(e.data), e.idx, e.idx == 3'd7);
                end
            end
        end
    end

    function automatic int cref(input int n, input int k);
        real v;
        v = 16384.0 * $cos(real'((2*n+1)*(2*k+1)) * 3.14159265358979 / 32.0);
        return v >= 0.0 ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
    endfunction

    task automatic push_model(input blk_t yv);
        for (int n = 0; n < 8; n++) begin
            longint s;
            exp_t e;
            s = 0;
            for (int k = 0; k < 8; k++) s += longint'(cref(n, k)) * longint'(yv[k]);
            e.data = 21'(s >>> 14);
            e.idx = 3'(n);
            exp_q.push_back(e);
        end
    endtask

    task automatic push_impulse(input bit neg);
        for (int n = 0; n < 8; n++) begin
            exp_t e;
            e.data = 21'(neg ? -imp[n] : imp[n]);
            e.idx = 3'(n);
            exp_q.push_back(e);
        end
    endtask

    task automatic send_block(input blk_t yv, input bit gaps);
        for (int k = 0; k < 8; k++) begin
            bit rdy;
            bit done;
            if (gaps) begin
                bus.in_valid = 1'b0;
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            end
            bus.in_valid = 1'b1;
            bus.in_data = yv[k];
            done = 1'b0;
            for (int t = 0; t < 3000 && !done; t++) begin
                @(negedge clk);
                rdy = bus.in_ready;
                @(posedge clk); #1;
                done = rdy;
            end
            if (!done) begin
                errors++;
                $display("FAIL input_accept beat %0d not accepted within 3000 cycles", k);
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 6000 && exp_q.size() > 0; t++) @(negedge clk);
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain %0d outputs missing, expected 0", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.out_ready = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_last !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags in_ready=%b out_valid=%b out_last=%b expected 1 0 0", bus.in_ready, bus.out_valid, bus.out_last);
        end
        checks++;
        if (bus.out_data !== 21'd0 || bus.out_idx !== 3'd0) begin
            errors++;
            $display("FAIL reset_data out_data=%0d out_idx=%0d expected 0 0", $signed(bus.out_data), bus.out_idx);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_impulse();
        blk_t yv = '{default: 18'sd0};
        bus.out_ready = 1'b1;
        yv[0] = 18'sd16384;
        push_impulse(1'b0);
        send_block(yv, 1'b0);
        wait_drain();
    endtask

    task automatic test_neg_impulse();
        blk_t yv = '{default: 18'sd0};
        bus.out_ready = 1'b1;
        yv[0] = -18'sd16384;
        push_impulse(1'b1);
        send_block(yv, 1'b1);
        wait_drain();
    endtask

    task automatic test_symmetry();
        blk_t yv = '{default: 18'sd0};
        blk_t zv = '{default: 18'sd0};
        exp_t e;
        bus.out_ready = 1'b1;
        yv[3] = 18'sd16384;
        push_model(yv);
        e = exp_q[0];
        checks++;
        if (e.data !== 21'(cref(3, 0))) begin
            errors++;
            $display("FAIL symmetry_model d0=%0d expected C[3][0]=%0d", $signed(e.data), cref(3, 0));
        end
        send_block(yv, 1'b0);
        wait_drain();
        push_model(zv);
        send_block(zv, 1'b0);
        wait_drain();
    endtask

    task automatic test_extremes();
        blk_t lo = '{default: -18'sd131072};
        blk_t hi = '{default: 18'sd131071};
        blk_t mx = '{18'sd131071, -18'sd131072, 18'sd131071, -18'sd131072, 18'sd131071, -18'sd131072, 18'sd131071, -18'sd131072};
        bus.out_ready = 1'b1;
        push_model(lo);
        send_block(lo, 1'b0);
        push_model(hi);
        send_block(hi, 1'b0);
        push_model(mx);
        send_block(mx, 1'b0);
        wait_drain();
    endtask

    task automatic test_timing();
        blk_t yv = '{18'sd1000, -18'sd2000, 18'sd3000, -18'sd77777, 18'sd5, 18'sd0, -18'sd1, 18'sd99999};
        int edges;
        bit seen;
        bus.out_ready = 1'b0;
        push_model(yv);
        for (int k = 0; k < 8; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data = yv[k];
            @(posedge clk); #1;
        end
        bus.in_data = 18'h2AAAA;
        edges = 1;
        seen = 1'b0;
        for (int t = 0; t < 100 && !seen; t++) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
            else begin @(posedge clk); edges++; end
        end
        checks++;
        if (edges !== 19) begin
            errors++;
            $display("FAIL latency out_valid after %0d edges counting the Y7 accept edge, expected 19", edges);
        end
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== exp_q[0].data || bus.out_idx !== 3'd0 || bus.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL backpressure_hold cycle %0d valid=%b data=%0d idx=%0d in_ready=%b expected 1 %0d 0 0",
                         c, bus.out_valid, $signed(bus.out_data), bus.out_idx, bus.in_ready, $signed(exp_q[0].data));
            end
            @(negedge clk);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        seen = 1'b0;
        for (int t = 0; t < 400 && !seen; t++) begin
            @(negedge clk);
            checks++;
            if (bus.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL in_ready_low in_ready=%b before final handshake, expected 0", bus.in_ready);
            end
            if (bus.out_valid && bus.out_last) seen = 1'b1;
        end
        if (!seen) begin
            errors++;
            $display("FAIL final_handshake out_last never seen within 400 cycles, expected 1");
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL after_last in_ready=%b out_valid=%b expected 1 0", bus.in_ready, bus.out_valid);
        end
        @(posedge clk); #1;
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL timing_drain %0d outputs left, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset_mid();
        blk_t yv = '{default: 18'sd0};
        bus.out_ready = 1'b1;
        yv[0] = 18'sd16384;
        push_impulse(1'b0);
        for (int k = 0; k < 8; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data = yv[k];
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        repeat (46) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_comp in_ready=%b out_valid=%b expected 1 0", bus.in_ready, bus.out_valid);
        end
        checks++;
        if (exp_q.size() !== 6) begin
            errors++;
            $display("FAIL reset_mid_count %0d outputs pending, expected 6", exp_q.size());
        end
        exp_q.delete();
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data = 18'sd77;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        push_impulse(1'b0);
        send_block(yv, 1'b0);
        wait_drain();
    endtask

    task automatic test_random();
        bit done = 1'b0;
        fork
            begin
                for (int b = 0; b < 200; b++) begin
                    blk_t yv;
                    for (int k = 0; k < 8; k++) yv[k] = 18'($urandom_range(0, 262143));
                    push_model(yv);
                    send_block(yv, 1'b1);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        bus.out_ready = 1'b1;
        wait_drain();
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_neg_impulse();
        test_symmetry();
        test_extremes();
        test_timing();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
